// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC register, imem handshake and IF/ID register
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallF_i,
    input  logic                  FlushD_i,
    input  logic                  PCSrcE_i,
    input  logic [DATA_WIDTH-1:0] PCTargetE_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  imem_valid_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] PC_F_o,
    output logic [DATA_WIDTH-1:0] PC_Plus4_F_o,
    output logic                  valid_o
);

    // IDLE: free to issue; WAIT: request in flight; DISCARD: in-flight response
    // belongs to a squashed path; HOLD: word captured during a stall
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [DATA_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic                  deliver;
    logic [DATA_WIDTH-1:0] deliver_instr;
    logic [DATA_WIDTH-1:0] deliver_pc;
    logic [DATA_WIDTH-1:0] target_aligned;
    logic [DATA_WIDTH-1:0] pc_plus4;

    // Redirect targets are forced word-aligned; the PC never carries low bits
    assign target_aligned = PCTargetE_i & ~DATA_WIDTH'(3);
    assign pc_plus4       = pc_q + DATA_WIDTH'(4);

    // A new request only goes out from IDLE, and never in the cycle of a redirect
    assign imem_req_o  = (state_q == IDLE) && !rst && !PCSrcE_i;
    assign imem_addr_o = pc_q;

    // Next-state, PC and hold-buffer logic; redirect always wins over stall
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        deliver       = 1'b0;
        deliver_instr = imem_rdata_i;
        deliver_pc    = pc_q;
        case (state_q)
            IDLE: begin
                if (PCSrcE_i) begin
                    pc_d = target_aligned;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (PCSrcE_i) begin
                    pc_d    = target_aligned;
                    state_d = imem_valid_i ? IDLE : DISCARD;
                end else if (imem_valid_i) begin
                    pc_d = pc_plus4;
                    if (StallF_i) begin
                        hold_instr_d = imem_rdata_i;
                        hold_pc_d    = pc_q;
                        state_d      = HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (PCSrcE_i) begin
                    pc_d = target_aligned;
                end
                if (imem_valid_i) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (PCSrcE_i) begin
                    pc_d    = target_aligned;
                    state_d = IDLE;
                end else if (!StallF_i) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_instr_q;
                    deliver_pc    = hold_pc_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC and hold-buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    // IF/ID register: reset, then flush/redirect bubble, then stall hold, then deliver
    always_ff @(posedge clk) begin
        if (rst || FlushD_i || PCSrcE_i) begin
            instr_o      <= NOP_INSTR;
            PC_F_o       <= '0;
            PC_Plus4_F_o <= '0;
            valid_o      <= 1'b0;
        end else if (StallF_i) begin
            instr_o      <= instr_o;
            PC_F_o       <= PC_F_o;
            PC_Plus4_F_o <= PC_Plus4_F_o;
            valid_o      <= valid_o;
        end else if (deliver) begin
            instr_o      <= deliver_instr;
            PC_F_o       <= deliver_pc;
            PC_Plus4_F_o <= deliver_pc + DATA_WIDTH'(4);
            valid_o      <= 1'b1;
        end else begin
            instr_o      <= NOP_INSTR;
            PC_F_o       <= '0;
            PC_Plus4_F_o <= '0;
            valid_o      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with transaction-level model
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, pcsrc = 1'b0;
    logic [31:0] target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] rdata = 32'h0;
    logic        mvalid = 1'b0;
    logic [31:0] instr, pcf, pc4;
    logic        valid;

    logic        rst2 = 1'b1, valid2 = 1'b0, zero1 = 1'b0;
    logic [31:0] rdata2 = 32'h0, zero32 = 32'h0;
    logic        req2, v2;
    logic [31:0] addr2, instr2, pcf2, pc42;

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .StallF_i(stall), .FlushD_i(flush), .PCSrcE_i(pcsrc),
        .PCTargetE_i(target), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_rdata_i(rdata), .imem_valid_i(mvalid), .instr_o(instr), .PC_F_o(pcf),
        .PC_Plus4_F_o(pc4), .valid_o(valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk(clk), .rst(rst2), .StallF_i(zero1), .FlushD_i(zero1), .PCSrcE_i(zero1),
        .PCTargetE_i(zero32), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_rdata_i(rdata2), .imem_valid_i(valid2), .instr_o(instr2), .PC_F_o(pcf2),
        .PC_Plus4_F_o(pc42), .valid_o(v2)
    );

    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          stray = 1'b0;
    logic [31:0] last_req = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    // Model: fetch pointer, one outstanding fetch (possibly stale), one held word, IF/ID contents
    logic [31:0] m_pc = 32'h0, m_fpc = 32'h0, m_hinstr = 32'h0, m_hpc = 32'h0;
    bit          m_busy = 1'b0, m_stale = 1'b0, m_held = 1'b0;
    logic [31:0] e_instr = NOP, e_pc = 32'h0, e_pc4 = 32'h0;
    bit          e_valid = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_step(bit issued);
        bit          got, dlv;
        logic [31:0] d_instr, d_pc;
        d_instr = 32'h0;
        d_pc    = 32'h0;
        dlv     = 1'b0;
        if (rst) begin
            m_pc = 32'h0; m_busy = 0; m_stale = 0; m_held = 0;
            e_instr = NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
            return;
        end
        got = m_busy && !m_stale && mvalid;
        if (!pcsrc && !stall) begin
            if (m_held) begin
                dlv = 1; d_instr = m_hinstr; d_pc = m_hpc;
            end else if (got) begin
                dlv = 1; d_instr = rdata; d_pc = m_fpc;
            end
        end
        if (flush || pcsrc) begin
            e_instr = NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
        end else if (stall) begin
            e_valid = e_valid;
        end else if (dlv) begin
            e_instr = d_instr; e_pc = d_pc; e_pc4 = d_pc + 32'd4; e_valid = 1;
        end else begin
            e_instr = NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
        end
        if (m_held && (pcsrc || !stall)) m_held = 0;
        if (got && stall && !pcsrc) begin
            m_held = 1; m_hinstr = rdata; m_hpc = m_fpc;
        end
        if (issued) begin
            m_busy = 1; m_stale = 0; m_fpc = m_pc;
        end else if (m_busy && mvalid) begin
            m_busy = 0; m_stale = 0;
        end else if (m_busy && pcsrc) begin
            m_stale = 1;
        end
        if (pcsrc) m_pc = target & 32'hFFFF_FFFC;
        else if (got) m_pc = m_fpc + 32'd4;
    endfunction

    // One clock: memory drives its response, request checked, model advanced, IF/ID checked
    task automatic tick();
        bit exp_req;
        mvalid = 1'b0;
        rdata  = 32'h0;
        if (stray) begin
            mvalid = 1'b1;
            rdata  = 32'hDEAD_BEEF;
        end else if (mq.size() > 0 && mq[0].due == cyc) begin
            mvalid = 1'b1;
            rdata  = 32'hAAAA_0000 + mq[0].addr;
            void'(mq.pop_front());
        end
        #1;
        exp_req = !rst && !m_busy && !m_held && !pcsrc;
        chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        if (imem_req === 1'b1) begin
            last_req = imem_addr;
            mq.push_back('{imem_addr, cyc + lat});
        end
        model_step(exp_req);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) mq.delete();
        chk("instr_o", instr, e_instr);
        chk("PC_F_o", pcf, e_pc);
        chk("PC_Plus4_F_o", pc4, e_pc4);
        chk("valid_o", {31'h0, valid}, {31'h0, e_valid});
    endtask

    task automatic lit(string name, logic [31:0] exp_instr, logic [31:0] exp_pc, logic [31:0] exp_pc4, bit exp_v);
        chk({name, "_instr"}, instr, exp_instr);
        chk({name, "_pc"}, pcf, exp_pc);
        chk({name, "_pc4"}, pc4, exp_pc4);
        chk({name, "_valid"}, {31'h0, valid}, {31'h0, exp_v});
    endtask

    task automatic advance_to(logic [31:0] addr);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!m_busy && !m_held && m_pc == addr) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        chk("advance_to_bound", {31'h0, reached}, 32'h1);
    endtask

    initial begin
        rst = 1; tick(); tick();
        lit("reset", NOP, 32'h0, 32'h0, 1'b0);

        rst = 0; lat = 1;
        tick();
        chk("first_req_addr", last_req, 32'h0);
        tick(); lit("fetch0", 32'hAAAA_0000, 32'h0, 32'h4, 1'b1);
        tick(); lit("gap0", NOP, 32'h0, 32'h0, 1'b0);
        tick(); lit("fetch4", 32'hAAAA_0004, 32'h4, 32'h8, 1'b1);
        tick(); tick(); lit("fetch8", 32'hAAAA_0008, 32'h8, 32'hC, 1'b1);

        tick(); tick();
        stall = 1; tick(); tick(); tick();
        lit("stall_hold", 32'hAAAA_000C, 32'hC, 32'h10, 1'b1);
        stall = 0; tick();
        lit("after_stall", 32'hAAAA_0010, 32'h10, 32'h14, 1'b1);
        tick();
        chk("req_after_stall", last_req, 32'h14);
        flush = 1; tick(); flush = 0;
        lit("flush", NOP, 32'h0, 32'h0, 1'b0);

        advance_to(32'h20);
        lat = 3; tick();
        chk("req_0x20", last_req, 32'h20);
        pcsrc = 1; target = 32'h200; tick(); pcsrc = 0;
        tick(); tick();
        chk("no_req_while_stale", last_req, 32'h20);
        lit("stale_dropped", NOP, 32'h0, 32'h0, 1'b0);
        lat = 1; tick();
        chk("req_0x200", last_req, 32'h200);

        pcsrc = 1; target = 32'h103; tick(); pcsrc = 0;
        lit("redirect_with_valid", NOP, 32'h0, 32'h0, 1'b0);
        tick();
        chk("req_0x100", last_req, 32'h100);
        tick();
        lit("fetch100", 32'hAAAA_0100, 32'h100, 32'h104, 1'b1);

        lat = 3; tick();
        rst = 1; tick(); stray = 1; tick(); stray = 0; tick();
        lit("reset_in_wait", NOP, 32'h0, 32'h0, 1'b0);
        rst = 0; pcsrc = 1; target = 32'h0; stray = 1; tick(); stray = 0; pcsrc = 0;
        lit("stray_ignored", NOP, 32'h0, 32'h0, 1'b0);
        lat = 1; tick();
        chk("restart_req", last_req, 32'h0);
        tick();
        lit("restart_fetch", 32'hAAAA_0000, 32'h0, 32'h4, 1'b1);

        chk("d2_reset_valid", {31'h0, v2}, 32'h0);
        chk("d2_reset_instr", instr2, NOP);
        @(negedge clk); rst2 = 0; #1;
        chk("d2_req", {31'h0, req2}, 32'h1);
        chk("d2_addr", addr2, 32'hFFFF_FFFC);
        @(negedge clk); valid2 = 1; rdata2 = 32'h1234_5678;
        @(posedge clk); #1; valid2 = 0;
        chk("d2_pc", pcf2, 32'hFFFF_FFFC);
        chk("d2_pc4", pc42, 32'h0);
        chk("d2_instr", instr2, 32'h1234_5678);
        chk("d2_valid", {31'h0, v2}, 32'h1);
        @(negedge clk); #1;
        chk("d2_wrap_req", {31'h0, req2}, 32'h1);
        chk("d2_wrap_addr", addr2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
